// File: rtl/baud_gen_pkg.sv
// Shared types and constants for the fractional baud tick generator.
package baud_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  typedef enum logic {
    OSR_X16 = 1'b0,
    OSR_X8  = 1'b1
  } osr_e;

  localparam int OSR16 = 16;
  localparam int OSR8  = 8;

  // Value of the oversample counter on the rx_tick that is also a bit tick.
  function automatic logic [3:0] osr_last(input osr_e sel);
    return (sel == OSR_X8) ? 4'(OSR8 - 1) : 4'(OSR16 - 1);
  endfunction

endpackage

// File: rtl/baud_gen_frac_if.sv
// Configuration handshake between the APB register block (master) and the baud generator (slave).
interface baud_gen_frac_if #(
  parameter int CNT_W  = 16,
  parameter int FRAC_W = 4
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CNT_W-1:0]  cfg_div_int;
  logic [FRAC_W-1:0] cfg_div_frac;
  logic              cfg_osr_sel;

  modport master (
    output cfg_valid, cfg_div_int, cfg_div_frac, cfg_osr_sel,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_div_int, cfg_div_frac, cfg_osr_sel,
    output cfg_ready
  );
endinterface

// File: rtl/baud_frac_div.sv
// Fractional interval divider: interval length is div_int plus the carry of a phase accumulator.
module baud_frac_div #(
  parameter int CNT_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_clear,
  input  logic [CNT_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  output logic              o_rx_tick
);

  logic [CNT_W-1:0]  r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic              r_rx_tick;
  logic [FRAC_W:0]   w_sum;
  logic [CNT_W:0]    w_len;
  logic [CNT_W:0]    w_last;
  logic              w_wrap;

  // r_acc holds the phase at the start of the current interval, so the carry
  // that stretches this interval is stable for its whole duration.
  assign w_sum  = {1'b0, r_acc} + {1'b0, i_div_frac};
  assign w_len  = {1'b0, i_div_int} + {{CNT_W{1'b0}}, w_sum[FRAC_W]};
  assign w_last = w_len - {{CNT_W{1'b0}}, 1'b1};
  assign w_wrap = ({1'b0, r_cnt} == w_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_rx_tick <= 1'b0;
    end else if (i_clear) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_rx_tick <= 1'b0;
    end else begin
      r_rx_tick <= w_wrap;
      if (w_wrap) begin
        r_cnt <= '0;
        r_acc <= w_sum[FRAC_W-1:0];
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_rx_tick = r_rx_tick;

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud tick generator: FSM, shadow config, oversample counter and handshake.
// Optional BAUD_GEN_BCLK_EN adds a legacy square wave on bclk toggling every rx_tick.
module baud_gen_frac
  import baud_gen_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int FRAC_W  = 4,
  parameter int MIN_DIV = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  baud_gen_frac_if.slave  cfg,
  output logic            rx_tick,
  output logic            tx_tick,
  output logic            locked,
  output logic            cfg_error,
  output logic            bclk
);

  localparam logic [1:0]       S_IDLE    = ST_IDLE;
  localparam logic [1:0]       S_RUN     = ST_RUN;
  localparam logic [1:0]       S_PEND    = ST_PEND;
  localparam logic [CNT_W-1:0] MIN_DIV_V = CNT_W'(MIN_DIV);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_div_int;
  logic [FRAC_W-1:0] r_div_frac;
  osr_e              r_osr;
  logic [CNT_W-1:0]  r_sh_div_int;
  logic [FRAC_W-1:0] r_sh_div_frac;
  osr_e              r_sh_osr;
  logic              r_cfg_error;
  logic [3:0]        r_os_cnt;

  logic w_accept;
  logic w_in_legal;
  logic w_sh_legal;
  logic w_act_legal;
  logic w_apply_in;
  logic w_apply_sh;
  logic w_boundary;
  logic w_clear;
  logic w_rx_tick;
  logic w_tx_tick;

  assign cfg.cfg_ready = (r_state != S_PEND);
  assign w_accept      = cfg.cfg_valid && cfg.cfg_ready;
  assign w_in_legal    = (cfg.cfg_div_int >= MIN_DIV_V);
  assign w_sh_legal    = (r_sh_div_int >= MIN_DIV_V);
  assign w_act_legal   = (r_div_int >= MIN_DIV_V);

  // A config offered while stopping is applied directly rather than shadowed.
  assign w_apply_in = w_accept && ((r_state == S_IDLE) || !en);
  assign w_apply_sh = (r_state == S_PEND) && (!en || w_tx_tick);
  assign w_boundary = (r_state == S_PEND) && en && w_tx_tick;

  // The divider only counts while running; a bit-boundary reconfig restarts it
  // from zero on the cycle after tx_tick.
  assign w_clear = !(en && (r_state != S_IDLE)) || w_boundary;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (en && w_act_legal && !w_accept) w_state_nxt = S_RUN;
      S_RUN: begin
        if (!en)           w_state_nxt = S_IDLE;
        else if (w_accept) w_state_nxt = S_PEND;
      end
      S_PEND: begin
        if (!en)            w_state_nxt = S_IDLE;
        else if (w_tx_tick) w_state_nxt = w_sh_legal ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div_int   <= '0;
      r_div_frac  <= '0;
      r_osr       <= OSR_X16;
      r_cfg_error <= 1'b0;
    end else if (w_apply_in) begin
      r_div_int   <= cfg.cfg_div_int;
      r_div_frac  <= cfg.cfg_div_frac;
      r_osr       <= osr_e'(cfg.cfg_osr_sel);
      r_cfg_error <= !w_in_legal;
    end else if (w_apply_sh) begin
      r_div_int   <= r_sh_div_int;
      r_div_frac  <= r_sh_div_frac;
      r_osr       <= r_sh_osr;
      r_cfg_error <= !w_sh_legal;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sh_div_int  <= '0;
      r_sh_div_frac <= '0;
      r_sh_osr      <= OSR_X16;
    end else if (w_accept && (r_state == S_RUN) && en) begin
      r_sh_div_int  <= cfg.cfg_div_int;
      r_sh_div_frac <= cfg.cfg_div_frac;
      r_sh_osr      <= osr_e'(cfg.cfg_osr_sel);
    end
  end

  baud_frac_div #(
    .CNT_W  (CNT_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk        (clk),
    .rstn       (rstn),
    .i_clear    (w_clear),
    .i_div_int  (r_div_int),
    .i_div_frac (r_div_frac),
    .o_rx_tick  (w_rx_tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                r_os_cnt <= '0;
    else if (w_clear)         r_os_cnt <= '0;
    else if (w_rx_tick) begin
      if (r_os_cnt == osr_last(r_osr)) r_os_cnt <= '0;
      else                             r_os_cnt <= r_os_cnt + 4'd1;
    end
  end

  assign w_tx_tick = w_rx_tick && (r_os_cnt == osr_last(r_osr));

`ifdef BAUD_GEN_BCLK_EN
  logic r_bclk;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          r_bclk <= 1'b0;
    else if (w_rx_tick) r_bclk <= ~r_bclk;
  end

  assign bclk = r_bclk;
`else
  assign bclk = 1'b0;
`endif

  assign rx_tick   = w_rx_tick;
  assign tx_tick   = w_tx_tick;
  assign locked    = (r_state != S_IDLE);
  assign cfg_error = r_cfg_error;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: vector table, random configs vs closed-form model, corner sequences.
module tb_baud_gen_frac;
  localparam int CNT_W  = 16;
  localparam int FRAC_W = 4;

  logic clk = 1'b0;
  logic rstn, en;
  logic rx_tick, tx_tick, locked, cfg_error, bclk;

  baud_gen_frac_if #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) cfg_if ();

  baud_gen_frac #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .MIN_DIV(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .cfg       (cfg_if),
    .rx_tick   (rx_tick),
    .tx_tick   (tx_tick),
    .locked    (locked),
    .cfg_error (cfg_error),
    .bclk      (bclk)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int rxq[$], txq[$], expq[$];

  typedef struct {
    int div;
    int frac;
    bit osr;
    int first_rx;
    int rx16;
    int first_tx;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Time of the k-th rx_tick after lock: k intervals whose lengths sum to
  // k*div plus the number of whole units accumulated by k*frac.
  function automatic int model_rx(input int div, input int frac, input int k);
    return k * div + ((k * frac) >> FRAC_W);
  endfunction

  function automatic int rx_at(input int i);
    return (i < rxq.size()) ? rxq[i] : -1;
  endfunction

  function automatic int tx_at(input int i);
    return (i < txq.size()) ? txq[i] : -1;
  endfunction

  task automatic prog(input int div, input int frac, input bit osr);
    cfg_if.cfg_valid    = 1'b1;
    cfg_if.cfg_div_int  = CNT_W'(div);
    cfg_if.cfg_div_frac = FRAC_W'(frac);
    cfg_if.cfg_osr_sel  = osr;
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic start();
    en = 1'b1;
    for (int i = 0; i < 8 && !locked; i++) step();
    chk("lock_after_en", locked, 1);
  endtask

  task automatic stop();
    en = 1'b0;
    step();
    step();
  endtask

  task automatic record(input int ncyc);
    rxq.delete();
    txq.delete();
    for (int t = 0; t < ncyc; t++) begin
      if (rx_tick) rxq.push_back(t);
      if (tx_tick) txq.push_back(t);
      step();
    end
  endtask

  task automatic cmp_q(input string name, input bit use_tx);
    int n;
    n = use_tx ? txq.size() : rxq.size();
    chk({name, "_count"}, n, expq.size());
    for (int i = 0; i < expq.size() && i < n; i++)
      chk({name, "_time"}, use_tx ? txq[i] : rxq[i], expq[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad, cnt, t, div, frac, osrn, ncyc;
    bit osr;

    vt[0] = '{div: 4,  frac: 0,  osr: 1'b0, first_rx: 4,  rx16: 64,  first_tx: 64};
    vt[1] = '{div: 4,  frac: 8,  osr: 1'b1, first_rx: 4,  rx16: 72,  first_tx: 36};
    vt[2] = '{div: 10, frac: 0,  osr: 1'b0, first_rx: 10, rx16: 160, first_tx: 160};
    vt[3] = '{div: 2,  frac: 15, osr: 1'b1, first_rx: 2,  rx16: 47,  first_tx: 23};
    vt[4] = '{div: 3,  frac: 1,  osr: 1'b0, first_rx: 3,  rx16: 49,  first_tx: 49};
    vt[5] = '{div: 7,  frac: 4,  osr: 1'b1, first_rx: 7,  rx16: 116, first_tx: 58};

    rstn = 1'b0; en = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_div_int = '0;
    cfg_if.cfg_div_frac = '0; cfg_if.cfg_osr_sel = 1'b0;
    #1;
    chk("rst_rx_tick", rx_tick, 0);
    chk("rst_tx_tick", tx_tick, 0);
    chk("rst_locked", locked, 0);
    chk("rst_cfg_error", cfg_error, 0);
    chk("rst_cfg_ready", cfg_if.cfg_ready, 1);
    chk("rst_bclk", bclk, 0);
    step(); step();
    rstn = 1'b1;
    step();

    // enable with the reset config (div 0) must not lock nor flag an error
    en = 1'b1;
    step(); step(); step();
    chk("nocfg_locked", locked, 0);
    chk("nocfg_cfg_error", cfg_error, 0);
    en = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      prog(vt[v].div, vt[v].frac, vt[v].osr);
      start();
      record(vt[v].rx16 + 2);
      chk("vec_first_rx", rx_at(0), vt[v].first_rx);
      chk("vec_rx16", rx_at(15), vt[v].rx16);
      chk("vec_first_tx", tx_at(0), vt[v].first_tx);
      chk("vec_locked", locked, 1);
      chk("vec_cfg_error", cfg_error, 0);
      stop();
    end

    for (int r = 0; r < 8; r++) begin
      div  = int'($urandom_range(2, 24));
      frac = int'($urandom_range(0, 15));
      osr  = 1'($urandom_range(0, 1));
      osrn = osr ? 8 : 16;
      ncyc = model_rx(div, frac, osrn) + 3;
      prog(div, frac, osr);
      start();
      record(ncyc);
      expq.delete();
      for (int k = 1; model_rx(div, frac, k) < ncyc; k++) expq.push_back(model_rx(div, frac, k));
      cmp_q("rand_rx", 1'b0);
      expq.delete();
      for (int k = osrn; model_rx(div, frac, k) < ncyc; k += osrn) expq.push_back(model_rx(div, frac, k));
      cmp_q("rand_tx", 1'b1);
      stop();
    end

    // illegal divisor blocks running, a legal one recovers
    prog(1, 0, 0);
    chk("illegal_cfg_error", cfg_error, 1);
    chk("illegal_cfg_ready", cfg_if.cfg_ready, 1);
    en = 1'b1;
    cnt = 0; bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (rx_tick) cnt++;
      if (locked) bad++;
      step();
    end
    chk("illegal_rx_ticks", cnt, 0);
    chk("illegal_locked_cycles", bad, 0);
    prog(10, 0, 0);
    chk("legal_clears_error", cfg_error, 0);
    start();
    record(25);
    expq.delete(); expq.push_back(10); expq.push_back(20);
    cmp_q("recover_rx", 1'b0);
    stop();

    // reconfig mid-bit waits for the bit boundary, then restarts
    prog(4, 0, 0);
    start();
    rxq.delete(); txq.delete(); bad = 0;
    for (t = 0; t <= 100; t++) begin
      if (rx_tick) rxq.push_back(t);
      if (tx_tick) txq.push_back(t);
      if (cfg_if.cfg_ready != ((t <= 10) || (t >= 65))) bad++;
      cfg_if.cfg_valid   = (t == 10);
      cfg_if.cfg_div_int = CNT_W'(6);
      step();
    end
    cfg_if.cfg_valid = 1'b0;
    chk("reconf_ready_bad_cycles", bad, 0);
    expq.delete();
    for (int k = 1; k <= 16; k++) expq.push_back(4 * k);
    for (int s = 71; s <= 100; s += 6) expq.push_back(s);
    cmp_q("reconf_rx", 1'b0);
    expq.delete(); expq.push_back(64);
    cmp_q("reconf_tx", 1'b1);

    // an illegal shadow config takes effect at the next boundary and stops the generator
    prog(1, 0, 0);
    t++;
    while (!tx_tick && t < 400) begin
      step();
      t++;
    end
    chk("pend_illegal_tx_time", t, 161);
    step();
    chk("pend_illegal_cfg_error", cfg_error, 1);
    chk("pend_illegal_locked", locked, 0);
    chk("pend_illegal_rx", rx_tick, 0);
    stop();

    // en falling while a config is pending applies it immediately
    prog(4, 0, 0);
    chk("pend_en_err_clear", cfg_error, 0);
    start();
    for (int i = 0; i < 10; i++) step();
    prog(9, 0, 0);
    chk("pend_en_ready", cfg_if.cfg_ready, 0);
    for (int i = 0; i < 9; i++) step();
    en = 1'b0;
    step();
    chk("pend_en_locked", locked, 0);
    chk("pend_en_ready_back", cfg_if.cfg_ready, 1);
    start();
    record(20);
    expq.delete(); expq.push_back(9); expq.push_back(18);
    cmp_q("pend_en_rx", 1'b0);
    stop();

    // config held valid while disabled: last value wins
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div_frac = '0; cfg_if.cfg_osr_sel = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      cfg_if.cfg_div_int = (i == 0) ? CNT_W'(3) : (i == 1) ? CNT_W'(5) : CNT_W'(8);
      if (!cfg_if.cfg_ready) bad++;
      step();
    end
    cfg_if.cfg_valid = 1'b0;
    chk("held_valid_not_ready", bad, 0);
    start();
    record(20);
    expq.delete(); expq.push_back(8); expq.push_back(16);
    cmp_q("held_valid_rx", 1'b0);
    stop();

    // en low on the cycle before a tick suppresses it; restart begins a fresh interval
    prog(5, 0, 0);
    start();
    for (int i = 0; i < 9; i++) step();
    chk("en_off_pre_rx", rx_tick, 0);
    en = 1'b0;
    step();
    chk("en_off_rx_suppressed", rx_tick, 0);
    chk("en_off_locked", locked, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (rx_tick || tx_tick) cnt++;
      step();
    end
    chk("en_off_ticks", cnt, 0);
    start();
    record(12);
    expq.delete(); expq.push_back(5); expq.push_back(10);
    cmp_q("en_restart_rx", 1'b0);

    // asynchronous reset while a tick is high
    cnt = 0;
    while (!rx_tick && cnt < 10) begin
      step();
      cnt++;
    end
    chk("async_pre_rx", rx_tick, 1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rx_tick", rx_tick, 0);
    chk("async_tx_tick", tx_tick, 0);
    chk("async_locked", locked, 0);
    chk("async_cfg_ready", cfg_if.cfg_ready, 1);
    chk("async_bclk", bclk, 0);
    step();
    rstn = 1'b1;
    step(); step();
    chk("post_rst_locked", locked, 0);
    en = 1'b0;
    step();

    // bclk: toggles on each rx_tick with the macro, otherwise stuck at 0
    prog(3, 0, 0);
    start();
    bad = 0;
    for (t = 0; t < 30; t++) begin
      cnt = 0;
      for (int k = 1; model_rx(3, 0, k) < t; k++) cnt++;
`ifdef BAUD_GEN_BCLK_EN
      if (bclk !== 1'(cnt & 1)) bad++;
`else
      if (bclk !== 1'b0) bad++;
`endif
      step();
    end
    chk("bclk_bad_cycles", bad, 0);
    stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
